rr_link_arbiter: RTL and testbench

- Shares one narrow data link (data + en strobe, the sender→receiver format used by the CDC lab benches) between N_REQ requesters.
- Round-robin arbitration with a per-grant burst limit and a programmable idle gap between bursts.
- Sits between several traffic sources and a single link consumer such as a receiver or synchronizer input, all on one clock.

---
 rtl/rr_link_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_link_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_link_arbiter.sv
// rtl/rr_link_arbiter.sv - round-robin burst arbiter sharing one data/en link; ARB_SRC_ID_EN adds src_id
module rr_link_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W         = 4,
    parameter int MAX_BURST = 4,
    parameter int GAP_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    input  logic [GAP_W-1:0]     gap,
    output logic [W-1:0]         data,
    output logic                 en
`ifdef ARB_SRC_ID_EN
    ,
    output logic [$clog2(N_REQ)-1:0] src_id
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      cur_q, cur_d;
    logic [IW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [W-1:0]       data_q;
    logic               en_q;
    logic [IW-1:0]      src_q;

    logic [N_REQ-1:0]   ack_c;
    logic [IW-1:0]      sel;
    logic [IW-1:0]      win;
    logic               win_vld;
    logic               end_burst;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
        ack_c     = '0;
        sel       = cur_q;
        end_burst = 1'b0;
        win       = last_q;
        win_vld   = 1'b0;

        // Scan downward so the lowest offset after last_q is written last and wins.
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % N_REQ]) begin
                win     = IW'((int'(last_q) + k) % N_REQ);
                win_vld = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    ack_c[win] = 1'b1;
                    sel        = win;
                    cur_d      = win;
                    last_d     = win;
                    cnt_d      = CW'(1);
                    if (MAX_BURST == 1) end_burst = 1'b1;
                    else                state_d   = S_BURST;
                end
            end
            S_BURST: begin
                if (req[cur_q]) begin
                    ack_c[cur_q] = 1'b1;
                    cnt_d        = cnt_q + CW'(1);
                    if (cnt_d == CW'(MAX_BURST)) end_burst = 1'b1;
                end else begin
                    end_burst = 1'b1;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q <= GAP_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (end_burst) begin
            if (gap == '0) begin
                state_d = S_IDLE;
            end else begin
                state_d   = S_GAP;
                gap_cnt_d = gap;
            end
        end
    end

    assign ack = rst ? '0 : ack_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            last_q    <= IW'(N_REQ - 1);
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            src_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gap_cnt_q <= gap_cnt_d;
            en_q      <= |ack_c;
            if (|ack_c) begin
                data_q <= req_data[int'(sel)*W +: W];
                src_q  <= sel;
            end
        end
    end

    assign data = data_q;
    assign en   = en_q;

`ifdef ARB_SRC_ID_EN
    assign src_id = src_q;
`else
    logic unused_src;
    assign unused_src = ^src_q;
`endif

endmodule

// File: tb/tb_rr_link_arbiter.sv
// tb/tb_rr_link_arbiter.sv - randomized bench for rr_link_arbiter against a cycle-count reference model
module tb_rr_link_arbiter;

    localparam int N_REQ     = 4;
    localparam int W         = 4;
    localparam int MAX_BURST = 4;
    localparam int GAP_W     = 8;
    localparam int IW        = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*W-1:0]   req_data;
    logic [N_REQ-1:0]     ack;
    logic [GAP_W-1:0]     gap;
    logic [W-1:0]         data;
    logic                 en;
`ifdef ARB_SRC_ID_EN
    logic [IW-1:0]        src_id;
`endif

    rr_link_arbiter #(
        .N_REQ(N_REQ), .W(W), .MAX_BURST(MAX_BURST), .GAP_W(GAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .gap      (gap),
        .data     (data),
        .en       (en)
`ifdef ARB_SRC_ID_EN
        ,
        .src_id   (src_id)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester sources
    int               word  [N_REQ];
    int               acks  [N_REQ];
    int               limit [N_REQ];
    logic [N_REQ-1:0] active;
    bit               cont;
    bit               rnd;
    logic [N_REQ-1:0] prev_ack;
    logic [N_REQ-1:0] obs_ack;
    bit               seen_en;
    int               en_low_after;

    // Reference model: owner/beats/idle-cycles bookkeeping
    int               m_owner;
    int               m_beats;
    int               m_gap_left;
    int               m_last;
    int               m_win;
    logic             m_en;
    logic [W-1:0]     m_data;
    int               m_src;
    logic [N_REQ-1:0] exp_ack;

    task automatic model_eval();
        m_win   = -1;
        exp_ack = '0;
        if (rst) return;
        if (m_gap_left > 0) begin
            m_win = -1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                if (m_win < 0 && req[(m_last + k) % N_REQ]) m_win = (m_last + k) % N_REQ;
            end
        end else if (req[m_owner]) begin
            m_win = m_owner;
        end
        if (m_win >= 0) exp_ack[m_win] = 1'b1;
    endtask

    task automatic finish_burst();
        m_owner    = -1;
        m_gap_left = int'(gap);
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1; m_beats = 0; m_gap_left = 0; m_last = N_REQ - 1;
            m_en = 1'b0; m_data = '0; m_src = 0;
            return;
        end
        if (m_gap_left > 0) begin
            m_gap_left--;
            m_en = 1'b0;
            return;
        end
        if (m_win >= 0) begin
            m_en   = 1'b1;
            m_data = W'(word[m_win]);
            m_src  = m_win;
            if (m_owner < 0) begin
                m_owner = m_win; m_beats = 1; m_last = m_win;
            end else begin
                m_beats++;
            end
            if (m_beats == MAX_BURST) finish_burst();
        end else begin
            m_en = 1'b0;
            if (m_owner >= 0) finish_burst();
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            if (prev_ack[i]) begin
                word[i]++;
                acks[i]++;
            end
            if (!req[i] || prev_ack[i])
                req[i] = active[i] && (acks[i] < limit[i]) && (cont || $urandom_range(0, 3) != 0);
            req_data[i*W +: W] = W'(word[i]);
        end
        if (rnd) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) gap = GAP_W'($urandom_range(0, 3));
        end
        #2;
        model_eval();
        obs_ack = ack;
        check("ack", ack, exp_ack);
        @(posedge clk);
        #1;
        model_step();
        check("en", en, m_en);
        check("data", data, m_data);
`ifdef ARB_SRC_ID_EN
        check("src_id", src_id, IW'(m_src));
`endif
        prev_ack = exp_ack;
        if (en) seen_en = 1'b1;
        else if (seen_en) en_low_after++;
    endtask

    task automatic start_phase(input logic [N_REQ-1:0] act, input bit c, input int g, input bit r);
        active = act;
        cont   = c;
        rnd    = 1'b0;
        gap    = GAP_W'(g);
        for (int i = 0; i < N_REQ; i++) begin
            word[i]  = i;
            acks[i]  = 0;
            limit[i] = 1000000;
        end
        req      = act;
        prev_ack = '0;
        rst      = 1'b1;
        repeat (2) run_cycle();
        rst          = 1'b0;
        rnd          = r;
        seen_en      = 1'b0;
        en_low_after = 0;
    endtask

    initial begin
        req      = '1;
        req_data = '0;
        gap      = '0;
        rst      = 1'b1;

        // Reset with all requesting, then requester 0 first
        start_phase('1, 1'b1, 0, 1'b0);
        run_cycle();
        check("first_grant", obs_ack, 4'b0001);
        repeat (30) run_cycle();

        // Lone requester 1, counting data, full throughput
        start_phase(4'b0010, 1'b1, 0, 1'b0);
        repeat (20) run_cycle();
        check("single_en_gaps", en_low_after, 0);

        // All continuous, gap 0: round robin without bubbles
        start_phase('1, 1'b1, 0, 1'b0);
        repeat (40) run_cycle();
        check("rr_en_gaps", en_low_after, 0);

        // All continuous, gap 5
        start_phase('1, 1'b1, 5, 1'b0);
        repeat (60) run_cycle();

        // Requester 2 stops after two beats while 0 and 3 keep requesting
        start_phase(4'b1101, 1'b1, 0, 1'b0);
        limit[2] = 2;
        repeat (24) run_cycle();
        check("req2_beats", acks[2], 2);

        // Reset pulse during beat 2 of requester 1
        start_phase(4'b0010, 1'b1, 0, 1'b0);
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check("rst_en_low", en, 1'b0);
        rst    = 1'b0;
        active = 4'b1001;
        req[1] = 1'b0;
        run_cycle();
        check("post_rst_grant", obs_ack, 4'b0001);
        repeat (10) run_cycle();

        // Random traffic, random gaps, occasional resets
        start_phase('1, 1'b0, 2, 1'b1);
        repeat (1500) run_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
